ahbl_uart_rx: RTL
=================

// Module: ahbl_uart_rx
// PURPOSE
//  AHB-Lite slave UART receiver, 8N1, LSB first; receive-side counterpart of the SoC UART transmitter.
//  Samples the serial input at mid-bit using a programmable per-bit clock count.
//  Pushes received bytes into a small FIFO that the CPU drains by register reads.
//  Occupies one splitter slave slot (e.g. 0x6000_0000); registers decoded on HADDR[3:2].
// PARAMETERS
//  FIFO_DEPTH        4       receive FIFO entries; power of 2, >= 2
//  DEFAULT_PRESCALE  16'd433 PRESCALE reset value (clocks per bit = PRESCALE+1)
// PORTS
//  HCLK       in   1   clock
//  HRESETn    in   1   asynchronous reset, active low
//  HADDR      in   32  AHB address (only [3:2] decoded)
//  HTRANS     in   2   AHB transfer type; a transfer is valid when HTRANS[1]=1
//  HSIZE      in   3   ignored; all accesses are treated as 32-bit
//  HWRITE     in   1   1 = write
//  HREADY     in   1   bus ready
//  HSEL       in   1   slave select from splitter
//  HWDATA     in   32  write data (data phase)
//  HREADYOUT  out  1   constant 1 (zero wait states)
//  HRDATA     out  32  read data (data phase)
//  rx         in   1   serial input, idle high, asynchronous to HCLK
//  irq        out  1   level: FIFO not empty OR any sticky error flag set
// BEHAVIOUR
//  Reset: all outputs 0 except HREADYOUT=1; FIFO empty; flags 0; FSM IDLE;
//   PRESCALE=DEFAULT_PRESCALE; EN=0; rx synchronizer flops = 1.
//  AHB: address phase captured when HSEL & HREADY & HTRANS[1];
//   regs {valid, write, addr[3:2]} held for the data phase.
//   Write takes HWDATA in the data phase. HRDATA is combinational from the latched address.
//   HRDATA = 0 when no valid read is in progress.
//  Register map:
//   0x0 RXDATA   RO  [7:0] FIFO head; [31:8]=0. Read pops the FIFO if not empty.
//                    Read when empty returns 0 and sets no flag.
//   0x4 STATUS   [0] NOT_EMPTY (RO), [1] FULL (RO), [2] OVERRUN, [3] FRAME_ERR.
//                    Bits [2] and [3] are sticky; writing 1 clears them.
//   0x8 PRESCALE RW  [15:0]; a new value is used at the next bit-counter reload.
//   0xC CTRL     RW  [0] EN; unused bits read 0.
//  Input: rx passes through a 2-flop synchronizer (rx_s); edge detection uses rx_s and its previous value.
//  Bit counter: cnt loads a value and counts down to 0; the sample point is cnt==0.
//  FSM:
//   IDLE : if EN & rx_s falling edge, load cnt=PRESCALE>>1 and go to START.
//   START: at cnt==0, if rx_s==1 the start was a glitch: go to IDLE.
//          Otherwise load cnt=PRESCALE, bit index=0, go to DATA.
//   DATA : at cnt==0, shift rx_s into bit[idx] (LSB first) and reload cnt.
//          After idx==7, go to STOP.
//   STOP : at cnt==0:
//          rx_s==0 -> set FRAME_ERR, discard the byte.
//          rx_s==1 and FIFO has room -> push the byte.
//          rx_s==1 and FIFO full -> set OVERRUN, discard the byte.
//          In every case return to IDLE. The next start can be detected the following cycle.
//  Latency: push occurs about 9.5 bit times plus 3 clocks after the start edge.
//  Simultaneous push and pop: both happen. If FIFO is full, the pop frees the slot,
//   so the push succeeds and OVERRUN is not set.
//  Simultaneous W1C write and a new error in the same cycle: set wins.
//  EN cleared mid-frame: FSM goes to IDLE next cycle and the partial byte is discarded.
//   FIFO contents are kept.
//  FIFO pointers have log2(FIFO_DEPTH)+1 bits and wrap naturally.
//   Full = MSBs differ and low bits are equal.
//  Reset asserted mid-frame: everything returns to reset state asynchronously.
// TESTING
//  1. PRESCALE=9, EN=1, drive 0xA5 as 8N1 at 10 clk/bit ->
//     STATUS=0x1 and irq=1; RXDATA reads 0xA5; then STATUS=0x0 and irq=0.
//  2. Send 5 bytes 0x01..0x05 with no reads (FIFO_DEPTH=4) -> STATUS=0x7.
//     Reads return 0x01..0x04. Write STATUS=0x4 -> OVERRUN cleared.
//  3. Send 0x3C with the stop bit driven 0 -> STATUS[3]=1 and FIFO stays empty.
//     The following frame 0x55 is received correctly.
//  4. Drive a 3-clock low glitch on rx (PRESCALE=9) -> no push, no flags, FSM back in IDLE.
//  5. With the FIFO full, time an RXDATA read to the same cycle as the STOP push ->
//     no OVERRUN, and the FIFO stays full with the new byte at the tail.
//  6. Clear EN after 3 data bits, then set EN and send 0x81 -> only 0x81 is received.
//     Also assert HRESETn mid-frame -> all registers return to reset values.

Source files
------------

// File: rtl/ahbl_uart_rx.sv
// ahbl_uart_rx
//   AHB-Lite slave UART receiver (8N1, LSB first). The serial input is
//   synchronised and sampled at mid-bit using a programmable per-bit clock
//   count. Received bytes go into a small FIFO that the CPU drains by reading
//   RXDATA.
//
//   Registers (HADDR[3:2]):
//     0x0 RXDATA   RO  [7:0] FIFO head, read pops
//     0x4 STATUS       [0] NOT_EMPTY, [1] FULL, [2] OVERRUN (W1C), [3] FRAME_ERR (W1C)
//     0x8 PRESCALE RW  [15:0] clocks per bit minus one
//     0xC CTRL     RW  [0] EN
//
//   Ports:
//     HCLK, HRESETn          clock, async active-low reset
//     HADDR, HTRANS, HSIZE,  AHB-Lite address phase (HSIZE ignored)
//     HWRITE, HREADY, HSEL
//     HWDATA                 write data (data phase)
//     HREADYOUT              always 1 (zero wait states)
//     HRDATA                 read data (data phase, combinational)
//     rx                     serial input, idle high, asynchronous
//     irq                    FIFO not empty or any sticky error flag
//
//   Receiver FSM states:
//     state   | meaning
//     S_IDLE  | waiting for a falling edge on rx while enabled
//     S_START | counting to the middle of the start bit, glitch check
//     S_DATA  | sampling the 8 data bits at mid-bit
//     S_STOP  | sampling the stop bit, reporting the byte to the FIFO
module ahbl_uart_rx #(
  parameter int          FIFO_DEPTH       = 4,
  parameter logic [15:0] DEFAULT_PRESCALE = 16'd433
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic        HSEL,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  input  logic        rx,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // ---------------------------------------------------------------------
  // AHB address/data phase
  // ---------------------------------------------------------------------
  logic       ph_valid;
  logic       ph_write;
  logic [1:0] ph_idx;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ph_valid <= 1'b0;
      ph_write <= 1'b0;
      ph_idx   <= 2'd0;
    end else if (HREADY) begin
      ph_valid <= HSEL & HTRANS[1];
      ph_write <= HWRITE;
      ph_idx   <= HADDR[3:2];
    end
  end

  logic rd_en;
  logic wr_en;
  assign rd_en = ph_valid & ~ph_write;
  assign wr_en = ph_valid &  ph_write;

  assign HREADYOUT = 1'b1;

  // Bits of the bus that this slave never looks at.
  logic unused_bits;
  assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HSIZE, HWDATA[31:16]};

  // ---------------------------------------------------------------------
  // Configuration registers
  // ---------------------------------------------------------------------
  logic [15:0] prescale;
  logic        en;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      prescale <= DEFAULT_PRESCALE;
      en       <= 1'b0;
    end else if (wr_en) begin
      if (ph_idx == 2'd2) prescale <= HWDATA[15:0];
      if (ph_idx == 2'd3) en       <= HWDATA[0];
    end
  end

  // ---------------------------------------------------------------------
  // rx synchronizer and falling-edge detect
  // ---------------------------------------------------------------------
  logic rx_meta;
  logic rx_s;
  logic rx_prev;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  logic rx_fall;
  assign rx_fall = rx_prev & ~rx_s;

  // ---------------------------------------------------------------------
  // Receiver FSM. The stop-bit verdict is registered (done_*) and acted on
  // by the FIFO one cycle later.
  // ---------------------------------------------------------------------
  state_t      state;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        done_pulse;
  logic        done_ok;
  logic [7:0]  done_byte;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state      <= S_IDLE;
      cnt        <= 16'd0;
      bit_idx    <= 3'd0;
      shreg      <= 8'd0;
      done_pulse <= 1'b0;
      done_ok    <= 1'b0;
      done_byte  <= 8'd0;
    end else begin
      done_pulse <= 1'b0;
      if (state != S_IDLE && !en) begin
        // Disabling mid-frame abandons the partial byte.
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (en && rx_fall) begin
              cnt   <= prescale >> 1;
              state <= S_START;
            end
          end
          S_START: begin
            if (cnt == 16'd0) begin
              if (rx_s) begin
                state <= S_IDLE;
              end else begin
                cnt     <= prescale;
                bit_idx <= 3'd0;
                state   <= S_DATA;
              end
            end else begin
              cnt <= cnt - 16'd1;
            end
          end
          S_DATA: begin
            if (cnt == 16'd0) begin
              shreg[bit_idx] <= rx_s;
              cnt            <= prescale;
              if (bit_idx == 3'd7) state <= S_STOP;
              else                 bit_idx <= bit_idx + 3'd1;
            end else begin
              cnt <= cnt - 16'd1;
            end
          end
          S_STOP: begin
            if (cnt == 16'd0) begin
              done_pulse <= 1'b1;
              done_ok    <= rx_s;
              done_byte  <= shreg;
              state      <= S_IDLE;
            end else begin
              cnt <= cnt - 16'd1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------
  // Receive FIFO and sticky flags
  // ---------------------------------------------------------------------
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        overrun;
  logic        frame_err;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  logic pop;
  logic push;
  logic ovr_set;
  logic fe_set;
  logic st_wr;

  assign pop     = rd_en & (ph_idx == 2'd0) & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push    = done_pulse & done_ok & (~full | pop);
  assign ovr_set = done_pulse & done_ok & full & ~pop;
  assign fe_set  = done_pulse & ~done_ok;
  assign st_wr   = wr_en & (ph_idx == 2'd1);

  always_ff @(posedge HCLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= done_byte;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      // Set has priority over a simultaneous write-1-to-clear.
      overrun   <= ovr_set | (overrun   & ~(st_wr & HWDATA[2]));
      frame_err <= fe_set  | (frame_err & ~(st_wr & HWDATA[3]));
    end
  end

  assign irq = ~empty | overrun | frame_err;

  // ---------------------------------------------------------------------
  // Read data
  // ---------------------------------------------------------------------
  always_comb begin
    HRDATA = 32'd0;
    if (rd_en) begin
      case (ph_idx)
        2'd0: HRDATA = empty ? 32'd0 : {24'd0, mem[rd_ptr[AW-1:0]]};
        2'd1: HRDATA = {28'd0, frame_err, overrun, full, ~empty};
        2'd2: HRDATA = {16'd0, prescale};
        2'd3: HRDATA = {31'd0, en};
        default: HRDATA = 32'd0;
      endcase
    end
  end

endmodule
